// File: rtl/stitch_scheduler.sv
// stitch_scheduler: sequencer that captures a left and a right camera frame into the
// shared BRWM frame buffer, then streams both frames to the Grayscaler. While streaming
// it honours pause backpressure, and it finishes with a done pulse or a watchdog err pulse.
module stitch_scheduler #(
  parameter int unsigned FRAME_PIX = 256,
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned WDOG      = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cam_l_valid,
  input  logic [DATA_W-1:0] cam_l_data,
  input  logic              cam_r_valid,
  input  logic [DATA_W-1:0] cam_r_data,
  output logic              cam_l_en,
  output logic              cam_r_en,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              gs_en,
  input  logic              gs_pause,
  input  logic              gs_done,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned PIX_W = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam int unsigned WD_W  = (WDOG > 1) ? $clog2(WDOG) : 1;

  localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(FRAME_PIX - 1);
  localparam logic [ADDR_W-1:0] R_BASE   = ADDR_W'(FRAME_PIX);
  localparam logic [ADDR_W-1:0] RD_LAST  = ADDR_W'(2 * FRAME_PIX - 1);
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(WDOG - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CAP_L = 3'd1,
    CAP_R = 3'd2,
    GRAY  = 3'd3,
    GWAIT = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [PIX_W-1:0]   pix_cnt, pix_cnt_nxt;
  logic [ADDR_W-1:0]  rd_cnt, rd_cnt_nxt;
  logic [WD_W-1:0]    wdog, wdog_nxt;

  logic               cam_l_en_nxt, cam_r_en_nxt, gs_en_nxt;
  logic               mem_en_nxt, mem_rw_nxt;
  logic [ADDR_W-1:0]  mem_addr_nxt;
  logic [DATA_W-1:0]  mem_wdata_nxt;
  logic               busy_nxt, done_nxt, err_nxt;

  // State, counters and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pix_cnt   <= '0;
      rd_cnt    <= '0;
      wdog      <= '0;
      cam_l_en  <= 1'b0;
      cam_r_en  <= 1'b0;
      gs_en     <= 1'b0;
      mem_en    <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      pix_cnt   <= pix_cnt_nxt;
      rd_cnt    <= rd_cnt_nxt;
      wdog      <= wdog_nxt;
      cam_l_en  <= cam_l_en_nxt;
      cam_r_en  <= cam_r_en_nxt;
      gs_en     <= gs_en_nxt;
      mem_en    <= mem_en_nxt;
      mem_rw    <= mem_rw_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

  // Next-state and next-output decode; strobes default low, the rest hold
  always_comb begin
    state_nxt     = state;
    pix_cnt_nxt   = pix_cnt;
    rd_cnt_nxt    = rd_cnt;
    wdog_nxt      = wdog;
    cam_l_en_nxt  = cam_l_en;
    cam_r_en_nxt  = cam_r_en;
    gs_en_nxt     = gs_en;
    mem_en_nxt    = 1'b0;
    mem_rw_nxt    = mem_rw;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt    = CAP_L;
          cam_l_en_nxt = 1'b1;
        end
      end

      CAP_L: begin
        if (cam_l_en && cam_l_valid) begin
          mem_en_nxt    = 1'b1;
          mem_rw_nxt    = 1'b1;
          mem_addr_nxt  = ADDR_W'(pix_cnt);
          mem_wdata_nxt = cam_l_data;
          if (pix_cnt == PIX_LAST) begin
            pix_cnt_nxt  = '0;
            cam_l_en_nxt = 1'b0;
            cam_r_en_nxt = 1'b1;
            state_nxt    = CAP_R;
          end else begin
            pix_cnt_nxt = pix_cnt + PIX_W'(1);
          end
        end
      end

      CAP_R: begin
        if (cam_r_en && cam_r_valid) begin
          mem_en_nxt    = 1'b1;
          mem_rw_nxt    = 1'b1;
          mem_addr_nxt  = R_BASE + ADDR_W'(pix_cnt);
          mem_wdata_nxt = cam_r_data;
          if (pix_cnt == PIX_LAST) begin
            pix_cnt_nxt  = '0;
            cam_r_en_nxt = 1'b0;
            gs_en_nxt    = 1'b1;
            rd_cnt_nxt   = '0;
            state_nxt    = GRAY;
          end else begin
            pix_cnt_nxt = pix_cnt + PIX_W'(1);
          end
        end
      end

      GRAY: begin
        mem_rw_nxt = 1'b0;
        gs_en_nxt  = 1'b1;
        if (!gs_pause) begin
          mem_en_nxt   = 1'b1;
          mem_addr_nxt = rd_cnt;
          if (rd_cnt == RD_LAST) begin
            state_nxt = GWAIT;
            wdog_nxt  = '0;
          end else begin
            rd_cnt_nxt = rd_cnt + ADDR_W'(1);
          end
        end
      end

      GWAIT: begin
        gs_en_nxt = 1'b1;
        if (gs_done) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (wdog == WD_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          wdog_nxt = wdog + WD_W'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase

    // Abort beats everything but reset, including a same-cycle start, done or err
    if (abort) begin
      state_nxt = IDLE;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
    end

    // Any return to IDLE leaves no trace of the frame in counters or outputs
    if (state_nxt == IDLE) begin
      pix_cnt_nxt   = '0;
      rd_cnt_nxt    = '0;
      wdog_nxt      = '0;
      cam_l_en_nxt  = 1'b0;
      cam_r_en_nxt  = 1'b0;
      gs_en_nxt     = 1'b0;
      mem_en_nxt    = 1'b0;
      mem_rw_nxt    = 1'b0;
      mem_addr_nxt  = '0;
      mem_wdata_nxt = '0;
    end

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_stitch_scheduler.sv
// tb_stitch_scheduler: directed stimulus with a scoreboard queue of expected BRWM
// accesses and done/err pulses, drained by a monitor forked alongside the stimulus.
module tb_stitch_scheduler;

  localparam int unsigned FRAME_PIX = 4;
  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned WDOG      = 8;

  localparam int K_MEM  = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int              kind;
    logic            rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, abort;
  logic              cam_l_valid, cam_r_valid;
  logic [DATA_W-1:0] cam_l_data, cam_r_data;
  logic              cam_l_en, cam_r_en;
  logic              mem_en, mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              gs_en, gs_pause, gs_done;
  logic              busy, done, err;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  stitch_scheduler #(
    .FRAME_PIX(FRAME_PIX), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WDOG(WDOG)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cam_l_valid(cam_l_valid), .cam_l_data(cam_l_data),
    .cam_r_valid(cam_r_valid), .cam_r_data(cam_r_data),
    .cam_l_en(cam_l_en), .cam_r_en(cam_r_en),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .gs_en(gs_en), .gs_pause(gs_pause), .gs_done(gs_done),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input logic rw, input int addr, input int data);
    exp_t e;
    e.kind = kind;
    e.rw   = rw;
    e.addr = ADDR_W'(addr);
    e.data = DATA_W'(data);
    sb.push_back(e);
  endtask

  // Pops one expectation for an observed event and compares it
  task automatic observe(input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event actual=kind%0d addr=%0h required=none t=%0t",
               kind, mem_addr, $time);
    end else begin
      e = sb.pop_front();
      chk("event_kind", 32'(kind), 32'(e.kind));
      if (kind == K_MEM && e.kind == K_MEM) begin
        chk("mem_rw", 32'(mem_rw), 32'(e.rw));
        chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        if (e.rw) chk("mem_wdata", 32'(mem_wdata), 32'(e.data));
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (mem_en) observe(K_MEM);
      if (done)   observe(K_DONE);
      if (err)    observe(K_ERR);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic capture(input int lb, input int rb);
    for (int i = 0; i < int'(FRAME_PIX); i++) begin
      cam_l_valid = 1'b1;
      cam_l_data  = DATA_W'(lb + i);
      push(K_MEM, 1'b1, i, lb + i);
      step();
    end
    cam_l_valid = 1'b0;
    chk("cap_l_en_low", 32'(cam_l_en), 32'd0);
    chk("cap_r_en_high", 32'(cam_r_en), 32'd1);
    for (int i = 0; i < int'(FRAME_PIX); i++) begin
      cam_r_valid = 1'b1;
      cam_r_data  = DATA_W'(rb + i);
      push(K_MEM, 1'b1, int'(FRAME_PIX) + i, rb + i);
      step();
    end
    cam_r_valid = 1'b0;
    chk("cap_r_en_low", 32'(cam_r_en), 32'd0);
    chk("gs_en_high", 32'(gs_en), 32'd1);
  endtask

  task automatic reads(input int first, input int n);
    gs_pause = 1'b0;
    for (int i = 0; i < n; i++) begin
      push(K_MEM, 1'b0, first + i, 0);
      step();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cam_l_en"}, 32'(cam_l_en), 32'd0);
    chk({tag, "_cam_r_en"}, 32'(cam_r_en), 32'd0);
    chk({tag, "_gs_en"}, 32'(gs_en), 32'd0);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_mem_rw"}, 32'(mem_rw), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic pat [7];
    int   wr;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cam_l_valid = 1'b0; cam_r_valid = 1'b0; cam_l_data = '0; cam_r_data = '0;
    gs_pause = 1'b0; gs_done = 1'b0;
    fork
      monitor();
    join_none

    // Reset state
    step();
    step();
    chk_all_zero("reset");
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    rst = 1'b0;
    step();

    // Continuous capture, paused read-out with an ignored start, then done
    pulse_start();
    chk("start_cam_l_en", 32'(cam_l_en), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    capture(8'h10, 8'h20);
    reads(0, 3);
    gs_pause = 1'b1;
    start    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      start = 1'b0;
      chk("pause_mem_en", 32'(mem_en), 32'd0);
      chk("pause_addr_hold", 32'(mem_addr), 32'd2);
    end
    reads(3, 5);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("gwait_gs_en", 32'(gs_en), 32'd1);
      chk("gwait_no_done", 32'(done), 32'd0);
    end
    gs_done = 1'b1;
    push(K_DONE, 1'b0, 0, 0);
    step();
    gs_done = 1'b0;
    chk_all_zero("after_done");
    step();
    chk("done_one_cycle", 32'(done), 32'd0);

    // Gapped left capture, stray right valid, then abort in mid right frame
    pulse_start();
    cam_r_valid = 1'b1;
    wr = 0;
    for (int k = 0; k < 7; k++) begin
      cam_l_valid = pat[k];
      cam_l_data  = DATA_W'(8'h30 + k);
      if (pat[k]) begin
        push(K_MEM, 1'b1, wr, 8'h30 + k);
        wr++;
      end
      step();
    end
    cam_r_valid = 1'b0;
    chk("gap_cam_r_en", 32'(cam_r_en), 32'd1);
    chk("gap_cam_l_en", 32'(cam_l_en), 32'd0);
    cam_l_valid = 1'b1;
    step();
    cam_l_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cam_r_valid = 1'b1;
      cam_r_data  = DATA_W'(8'h40 + i);
      push(K_MEM, 1'b1, 4 + i, 8'h40 + i);
      step();
    end
    cam_r_data = 8'h42;
    abort      = 1'b1;
    step();
    abort       = 1'b0;
    cam_r_valid = 1'b0;
    chk_all_zero("abort");
    step();
    chk("abort_stays_idle", 32'(busy), 32'd0);

    // Watchdog expiry with no gs_done
    pulse_start();
    capture(8'h50, 8'h60);
    reads(0, 8);
    for (int k = 1; k <= int'(WDOG); k++) begin
      if (k == int'(WDOG)) push(K_ERR, 1'b0, 0, 0);
      step();
      chk("wdog_err", 32'(err), (k == int'(WDOG)) ? 32'd1 : 32'd0);
    end
    chk("wdog_busy", 32'(busy), 32'd0);
    chk("wdog_gs_en", 32'(gs_en), 32'd0);
    step();
    chk("err_one_cycle", 32'(err), 32'd0);

    // Restart from addr 0, then async reset in mid read-out
    pulse_start();
    capture(8'h70, 8'h80);
    reads(0, 1);
    gs_pause = 1'b1;
    step();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    step();
    rst      = 1'b0;
    gs_pause = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_idle", 32'(busy), 32'd0);
      chk("post_rst_mem_en", 32'(mem_en), 32'd0);
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stitch_scheduler.md
Name: stitch_scheduler

Overview:
Top-level sequencer for the video stitcher datapath. Captures one frame from the left camera and one from the right camera into the shared single-port BRWM frame buffer, then streams both frames to the Grayscaler with pause backpressure. It owns all BRWM enable, read/write and address control and reports completion or watchdog error.

Parameters:
FRAME_PIX, 256, pixels per camera frame
ADDR_W, 9, BRWM address width; must satisfy 2^ADDR_W >= 2*FRAME_PIX
DATA_W, 8, pixel width
WDOG, 1023, max cycles to wait for gs_done after the last read

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle start request, honoured only in IDLE
abort  in  1  synchronous abort to IDLE, priority over everything except rst
cam_l_valid  in  1  left pixel valid
cam_l_data  in  DATA_W  left pixel
cam_r_valid  in  1  right pixel valid
cam_r_data  in  DATA_W  right pixel
cam_l_en  out  1  left camera enable
cam_r_en  out  1  right camera enable
mem_en  out  1  BRWM access strobe
mem_rw  out  1  1=write, 0=read
mem_addr  out  ADDR_W  BRWM address
mem_wdata  out  DATA_W  BRWM write data
gs_en  out  1  Grayscaler enable
gs_pause  in  1  Grayscaler backpressure
gs_done  in  1  Grayscaler finished last pixel
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle watchdog timeout pulse

Behaviour:
- All outputs registered. Reset (rst high, async): state=IDLE, every output 0, counters 0.
- States: IDLE, CAP_L, CAP_R, GRAY, GWAIT.
- IDLE: start=1 -> CAP_L; cam_l_en=1 and busy=1 from the next edge. start in any other state is ignored.
- CAP_L: each cycle with cam_l_en=1 and cam_l_valid=1 is accepted. On the next edge: mem_en=1, mem_rw=1, mem_addr=pix_cnt, mem_wdata=cam_l_data, pix_cnt++. This is a 1-cycle write latency. Cycles without valid drive mem_en=0.
- At the FRAME_PIX-th accepted left pixel: on the same edge, cam_l_en=0, cam_r_en=1, pix_cnt=0, state=CAP_R. Valid pixels after cam_l_en drops are ignored.
- CAP_R: same as CAP_L with the right camera, mem_addr=FRAME_PIX+pix_cnt. At the FRAME_PIX-th pixel: cam_r_en=0, gs_en=1, rd_cnt=0, state=GRAY.
- GRAY: mem_rw=0, gs_en=1.
  - gs_pause=0: mem_en=1, mem_addr=rd_cnt, rd_cnt++.
  - gs_pause=1: mem_en=0; mem_addr and rd_cnt hold.
  - After address 2*FRAME_PIX-1 is issued: state=GWAIT, mem_en=0, wdog=0.
- GWAIT: gs_en stays 1, wdog increments each cycle.
  - gs_done=1: done=1 for one cycle, gs_en=0, state=IDLE.
  - gs_done=1 on the same cycle wdog reaches WDOG: done wins.
  - wdog reaches WDOG without gs_done: err=1 for one cycle, state=IDLE.
  - gs_done seen outside GWAIT is ignored.
- abort=1 in any non-IDLE state: next edge -> IDLE, all enables 0, counters 0, no done or err. abort together with start in IDLE: stay IDLE.
- mem_addr arithmetic is ADDR_W bits with no wrap. The capture counters never exceed FRAME_PIX-1; the read counter never exceeds 2*FRAME_PIX-1.
- rst asserted mid-frame: immediate return to reset values. No partial-frame state survives.

Test Plan:
- FRAME_PIX=4. start, then 4 continuous left pixels 0x10..0x13 and 4 right pixels 0x20..0x23 -> writes addr 0..3 then 4..7 with matching data, each 1 cycle after valid; cam_l_en falls and cam_r_en rises on the same edge.
- Gapped cam_l_valid (1,0,0,1,1,0,1) -> exactly 4 writes to addrs 0..3, mem_en=0 on gap cycles; valid asserted while cam_r_en=0 produces no write.
- GRAY with gs_pause high for 3 cycles after addr 2 -> read addrs 0,1,2 then hold at 2 with mem_en=0 for 3 cycles, resume at 3..7; gs_done 5 cycles later -> done pulses once, busy falls, all outputs 0.
- WDOG=8, gs_done never asserted -> err is a 1-cycle pulse 8 cycles after GWAIT entry, no done, state IDLE; a new start then re-runs a capture from addr 0.
- abort during CAP_R pixel 2 -> next cycle all enables 0, busy=0; start pulse during GRAY ignored (addr sequence unchanged).
- rst pulse mid-GRAY (async, between edges) -> outputs 0 immediately; after release, idle until start.
